// File: rtl/aq_cp0_maint_arb_pkg.sv
// Shared CP0 maintenance definitions: FSM state, target/op/source codes and
// arbitration defaults used by the maintenance arbiter and its priority picker.
package aq_cp0_maint_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RLS  = 2'b10,
    ST_ILL  = 2'b11
  } arb_state_e;

  typedef enum logic [1:0] {
    TGT_NOP = 2'b00,
    TGT_DCA = 2'b01,
    TGT_ICA = 2'b10,
    TGT_MMU = 2'b11
  } maint_tgt_e;

  typedef enum logic [1:0] {
    OP_INV     = 2'b00,
    OP_CLN     = 2'b01,
    OP_CLN_INV = 2'b10,
    OP_RSVD    = 2'b11
  } maint_op_e;

  typedef enum logic [1:0] {
    SRC_FNC  = 2'b00,
    SRC_CSR  = 2'b01,
    SRC_DBG  = 2'b10,
    SRC_NONE = 2'b11
  } maint_src_e;

  localparam logic [1:0] STARVE_LIM_DEF = 2'd3;

  typedef struct packed {
    logic [1:0] tgt;
    logic [1:0] op;
  } maint_cmd_t;

  // The reserved op encoding is executed as a plain invalidate.
  function automatic logic [1:0] norm_op(input logic [1:0] op);
    logic [1:0] res;
    res = op;
    if (op == OP_RSVD) begin
      res = OP_INV;
    end
    return res;
  endfunction

endpackage

// File: rtl/aq_cp0_maint_prio.sv
// Combinational 3-way fixed-priority picker (fence > debug > CSR) with a
// starvation override that lets a pending CSR request beat everyone.
module aq_cp0_maint_prio
  import aq_cp0_maint_arb_pkg::*;
(
  input  logic       fnc_req,
  input  logic       csr_req,
  input  logic       dbg_req,
  input  logic       starve_hit,
  output logic       win_vld,
  output maint_src_e win_src
);

  // NOTE: every output gets a default first so no path through the block
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    win_vld = fnc_req | csr_req | dbg_req;
    win_src = SRC_NONE;
    if (csr_req && starve_hit) begin
      win_src = SRC_CSR;
    end else if (fnc_req) begin
      win_src = SRC_FNC;
    end else if (dbg_req) begin
      win_src = SRC_DBG;
    end else if (csr_req) begin
      win_src = SRC_CSR;
    end
  end

endmodule

// File: rtl/aq_cp0_maint_arb.sv
// Arbiter/sequencer for the single CP0 maintenance engine port: grants one of
// fence/CSR/debug, drives the engine until done, and routes completion back.
module aq_cp0_maint_arb
  import aq_cp0_maint_arb_pkg::*;
#(
  parameter logic [1:0] STARVE_LIM = STARVE_LIM_DEF,
  parameter logic [1:0] NOP_TGT    = 2'b00
) (
  input  logic       fence_clk,
  input  logic       cpurst_b,
  input  logic       fnc_req,
  input  logic [1:0] fnc_tgt,
  input  logic [1:0] fnc_op,
  input  logic       csr_req,
  input  logic [1:0] csr_tgt,
  input  logic [1:0] csr_op,
  input  logic       dbg_req,
  input  logic [1:0] dbg_tgt,
  input  logic [1:0] dbg_op,
  input  logic       maint_done,
  output logic       maint_req,
  output logic [1:0] maint_tgt,
  output logic [1:0] maint_op,
  output logic [1:0] maint_src,
  output logic       fnc_done,
  output logic       csr_done,
  output logic       dbg_done,
  output logic       arb_busy,
  output logic       arb_clk_en,
  output logic [1:0] arb_cur_state
);

  arb_state_e state;
  logic [1:0] starve_cnt;
  logic       win_vld;
  maint_src_e win_src;
  maint_cmd_t win_cmd;

  aq_cp0_maint_prio u_prio (
    .fnc_req    (fnc_req),
    .csr_req    (csr_req),
    .dbg_req    (dbg_req),
    .starve_hit (starve_cnt == STARVE_LIM),
    .win_vld    (win_vld),
    .win_src    (win_src)
  );

  always_comb begin
    win_cmd = '0;
    case (win_src)
      SRC_FNC: win_cmd = '{tgt: fnc_tgt, op: norm_op(fnc_op)};
      SRC_CSR: win_cmd = '{tgt: csr_tgt, op: norm_op(csr_op)};
      SRC_DBG: win_cmd = '{tgt: dbg_tgt, op: norm_op(dbg_op)};
      default: win_cmd = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge fence_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state      <= ST_IDLE;
      starve_cnt <= 2'd0;
      maint_req  <= 1'b0;
      maint_tgt  <= 2'b00;
      maint_op   <= 2'b00;
      maint_src  <= 2'b00;
      fnc_done   <= 1'b0;
      csr_done   <= 1'b0;
      dbg_done   <= 1'b0;
    end else begin
      fnc_done <= 1'b0;
      csr_done <= 1'b0;
      dbg_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Starvation count only tracks grants that bypass a waiting CSR.
          if (!csr_req || win_src == SRC_CSR) begin
            starve_cnt <= 2'd0;
          end else if (starve_cnt != 2'b11) begin
            starve_cnt <= starve_cnt + 2'd1;
          end
          if (win_vld) begin
            state     <= ST_BUSY;
            maint_src <= win_src;
            maint_tgt <= win_cmd.tgt;
            maint_op  <= win_cmd.op;
            maint_req <= (win_cmd.tgt != NOP_TGT);
          end
        end
        ST_BUSY: begin
          if (maint_tgt == NOP_TGT || maint_done) begin
            state     <= ST_RLS;
            maint_req <= 1'b0;
            case (maint_src)
              SRC_FNC: fnc_done <= 1'b1;
              SRC_CSR: csr_done <= 1'b1;
              SRC_DBG: dbg_done <= 1'b1;
              default: ;
            endcase
          end
        end
        ST_RLS: begin
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          maint_req <= 1'b0;
        end
      endcase
    end
  end

  assign arb_busy      = (state != ST_IDLE);
  assign arb_clk_en    = arb_busy | fnc_req | csr_req | dbg_req;
  assign arb_cur_state = state;

endmodule

// File: tb/tb_aq_cp0_maint_arb.sv
// Directed self-checking bench for aq_cp0_maint_arb with hand-computed
// expectations for grant order, timing, starvation, NOP, reset and holds.
module tb_aq_cp0_maint_arb;

  logic       fence_clk = 1'b0;
  logic       cpurst_b  = 1'b0;
  logic       fnc_req = 1'b0, csr_req = 1'b0, dbg_req = 1'b0;
  logic [1:0] fnc_tgt = 2'b00, csr_tgt = 2'b00, dbg_tgt = 2'b00;
  logic [1:0] fnc_op = 2'b00, csr_op = 2'b00, dbg_op = 2'b00;
  logic       maint_done = 1'b0;
  logic       maint_req;
  logic [1:0] maint_tgt, maint_op, maint_src;
  logic       fnc_done, csr_done, dbg_done;
  logic       arb_busy, arb_clk_en;
  logic [1:0] arb_cur_state;

  int n_chk  = 0;
  int n_pass = 0;

  aq_cp0_maint_arb dut (
    .fence_clk     (fence_clk),
    .cpurst_b      (cpurst_b),
    .fnc_req       (fnc_req),
    .fnc_tgt       (fnc_tgt),
    .fnc_op        (fnc_op),
    .csr_req       (csr_req),
    .csr_tgt       (csr_tgt),
    .csr_op        (csr_op),
    .dbg_req       (dbg_req),
    .dbg_tgt       (dbg_tgt),
    .dbg_op        (dbg_op),
    .maint_done    (maint_done),
    .maint_req     (maint_req),
    .maint_tgt     (maint_tgt),
    .maint_op      (maint_op),
    .maint_src     (maint_src),
    .fnc_done      (fnc_done),
    .csr_done      (csr_done),
    .dbg_done      (dbg_done),
    .arb_busy      (arb_busy),
    .arb_clk_en    (arb_clk_en),
    .arb_cur_state (arb_cur_state)
  );

  always #5 fence_clk = ~fence_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are observed 1ns after the active edge.
  task automatic tick();
    @(posedge fence_clk);
    #1;
  endtask

  // Wait (bounded) for a grant, check it, run a 2-cycle engine op, check done.
  task automatic serve_one(input string tag, input logic [1:0] exp_src,
                           input logic [1:0] exp_cnt, input bit drop);
    int k;
    k = 0;
    while (!maint_req && k < 8) begin
      tick();
      k++;
    end
    check({tag, "_grant"}, 32'(maint_req), 32'd1);
    if (!maint_req) return;
    check({tag, "_src"}, 32'(maint_src), 32'(exp_src));
    check({tag, "_cnt"}, 32'(dut.starve_cnt), 32'(exp_cnt));
    tick();
    maint_done = 1'b1;
    tick();
    maint_done = 1'b0;
    check({tag, "_done"}, 32'({dbg_done, csr_done, fnc_done}), 32'(3'b001 << exp_src));
    if (drop) begin
      case (exp_src)
        2'd0:    fnc_req = 1'b0;
        2'd1:    csr_req = 1'b0;
        default: dbg_req = 1'b0;
      endcase
    end
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_state", 32'(arb_cur_state), 32'd0);
    check("rst_req",   32'(maint_req), 32'd0);
    check("rst_lat",   32'({maint_tgt, maint_op, maint_src}), 32'd0);
    check("rst_done",  32'({fnc_done, csr_done, dbg_done}), 32'd0);
    check("rst_busy",  32'(arb_busy), 32'd0);
    check("rst_clken", 32'(arb_clk_en), 32'd0);
    check("rst_cnt",   32'(dut.starve_cnt), 32'd0);
    cpurst_b = 1'b1;
    tick();

    // Single fence op, engine done at cycle 5
    fnc_req = 1'b1; fnc_tgt = 2'b01; fnc_op = 2'b10;
    #1;
    check("t1_clken", 32'(arb_clk_en), 32'd1);
    for (int c = 1; c <= 7; c++) begin
      tick();
      check($sformatf("t1_req_c%0d", c),   32'(maint_req), 32'(c >= 1 && c <= 5));
      check($sformatf("t1_fdone_c%0d", c), 32'(fnc_done),  32'(c == 6));
      if (c == 1) check("t1_lat", 32'({maint_tgt, maint_op, maint_src}), 32'(6'b01_10_00));
      if (c == 7) check("t1_idle", 32'(arb_cur_state), 32'd0);
      maint_done = (c == 5);
      if (c == 6) fnc_req = 1'b0;
    end

    // NOP debug op
    dbg_req = 1'b1; dbg_tgt = 2'b00; dbg_op = 2'b01;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("t4_req_c%0d", c),   32'(maint_req), 32'd0);
      check($sformatf("t4_ddone_c%0d", c), 32'(dbg_done),  32'(c == 2));
      if (c == 2) dbg_req = 1'b0;
    end
    check("t4_idle", 32'(arb_cur_state), 32'd0);

    // All three requesting: fence, debug, then CSR
    fnc_req = 1'b1; fnc_tgt = 2'b01; fnc_op = 2'b00;
    dbg_req = 1'b1; dbg_tgt = 2'b10; dbg_op = 2'b01;
    csr_req = 1'b1; csr_tgt = 2'b11; csr_op = 2'b10;
    serve_one("t2_a", 2'd0, 2'd1, 1'b1);
    serve_one("t2_b", 2'd2, 2'd2, 1'b1);
    serve_one("t2_c", 2'd1, 2'd0, 1'b1);
    check("t2_csr_tgt", 32'(maint_tgt), 32'd3);

    // Starvation: CSR held while fence keeps requesting
    fnc_req = 1'b1;
    csr_req = 1'b1;
    serve_one("t3_f1", 2'd0, 2'd1, 1'b0);
    serve_one("t3_f2", 2'd0, 2'd2, 1'b0);
    serve_one("t3_f3", 2'd0, 2'd3, 1'b0);
    serve_one("t3_c",  2'd1, 2'd0, 1'b1);
    serve_one("t3_f4", 2'd0, 2'd0, 1'b1);
    tick();
    check("t3_idle", 32'(arb_cur_state), 32'd0);

    // Reset mid-operation
    fnc_req = 1'b1; fnc_tgt = 2'b10; fnc_op = 2'b00;
    tick();
    tick();
    tick();
    check("t5_busy_req", 32'(maint_req), 32'd1);
    #2 cpurst_b = 1'b0;
    #1;
    check("t5_rst_req",   32'(maint_req), 32'd0);
    check("t5_rst_state", 32'(arb_cur_state), 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("t5_nodone_%0d", c), 32'({fnc_done, csr_done, dbg_done}), 32'd0);
    end
    #2 cpurst_b = 1'b1;
    #1;
    check("t5_pre_edge", 32'(maint_req), 32'd0);
    tick();
    check("t5_regrant", 32'(maint_req), 32'd1);
    check("t5_lat", 32'({maint_tgt, maint_src}), 32'(4'b10_00));
    tick();
    maint_done = 1'b1;
    tick();
    maint_done = 1'b0;
    check("t5_fdone", 32'(fnc_done), 32'd1);
    fnc_req = 1'b0;
    tick();

    // Reserved op is executed as invalidate
    dbg_req = 1'b1; dbg_tgt = 2'b01; dbg_op = 2'b11;
    tick();
    check("rsv_op", 32'({maint_tgt, maint_op}), 32'(4'b01_00));
    serve_one("rsv", 2'd2, 2'd0, 1'b1);
    tick();

    // Stray done in IDLE and input change mid-BUSY are ignored
    maint_done = 1'b1;
    tick();
    maint_done = 1'b0;
    check("t6_idle_state", 32'(arb_cur_state), 32'd0);
    check("t6_idle_done",  32'({fnc_done, csr_done, dbg_done, maint_req}), 32'd0);
    fnc_req = 1'b1; fnc_tgt = 2'b11; fnc_op = 2'b01;
    tick();
    fnc_tgt = 2'b01; fnc_op = 2'b00;
    tick();
    tick();
    check("t6_hold", 32'({maint_tgt, maint_op}), 32'(4'b11_01));
    maint_done = 1'b1;
    tick();
    maint_done = 1'b0;
    check("t6_fdone", 32'(fnc_done), 32'd1);
    check("t6_rls_tgt", 32'(maint_tgt), 32'd3);
    fnc_req = 1'b0;
    tick();
    check("t6_end_state", 32'(arb_cur_state), 32'd0);
    check("t6_end_tgt", 32'(maint_tgt), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
